// File: rtl/jailbreak_hs_sequencer.sv
// Halts the Jailbreak CPU and moves a block of bytes between the bridge byte streams and
// the core's high-score RAM port. Optional abort/aborted ports: define JB_HS_SEQ_ABORT_EN.
module jailbreak_hs_sequencer #(
  parameter int ADDR_WIDTH   = 12,
  parameter int LEN_WIDTH    = 13,
  parameter int HALT_SETTLE  = 4,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef JB_HS_SEQ_ABORT_EN
  input  logic                  abort,
  output logic                  aborted,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [7:0]            wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [7:0]            rd_data,
  output logic [ADDR_WIDTH-1:0] hs_address,
  output logic [7:0]            hs_data_in,
  input  logic [7:0]            hs_data_out,
  output logic                  hs_write_enable,
  output logic                  hs_access_write,
  output logic                  processor_halt,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_MAX = (HALT_SETTLE > READ_LATENCY) ? HALT_SETTLE : READ_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Wide enough that addr+len can never wrap, whatever the length field carries.
  localparam int SUM_W   = ((LEN_WIDTH > ADDR_WIDTH) ? LEN_WIDTH : ADDR_WIDTH) + 1;
  localparam logic [SUM_W-1:0] ADDR_SPAN   = SUM_W'(1) << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(HALT_SETTLE - 1);
  localparam logic [CNT_W-1:0] RDLAT_LOAD  = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
    S_RWAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  write_q, write_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  halt_q, halt_d;
  logic                  acc_wr_q, acc_wr_d;
  logic                  busy_q, busy_d;
  logic                  req_ready_q, req_ready_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  abort_in;
  logic                  abort_take;
  logic                  in_xfer;
  logic [SUM_W-1:0]      end_addr;

`ifdef JB_HS_SEQ_ABORT_EN
  logic                  aborted_q, aborted_d;
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  assign end_addr = SUM_W'(req_addr) + SUM_W'(req_len);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    write_d    = write_q;
    rd_data_d  = rd_data_q;
    error_d    = 1'b0;
    abort_take = abort_in && (state_q inside {S_HALT, S_ACCESS, S_RWAIT, S_EMIT});

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          rem_d   = req_len;
          if (req_len == '0) begin
            state_d = S_DONE;
          end else if (end_addr > ADDR_SPAN) begin
            error_d = 1'b1;
          end else begin
            state_d = S_HALT;
            cnt_d   = SETTLE_LOAD;
          end
        end
      end
      S_HALT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        if (write_q) begin
          if (wr_valid) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            rem_d  = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = S_DONE;
            end
          end
        end else begin
          state_d = S_RWAIT;
          cnt_d   = RDLAT_LOAD;
        end
      end
      S_RWAIT: begin
        if (cnt_q == '0) begin
          rd_data_d = hs_data_out;
          state_d   = S_EMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (rd_ready) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          rem_d   = rem_q - LEN_WIDTH'(1);
          state_d = (rem_q == LEN_WIDTH'(1)) ? S_DONE : S_ACCESS;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_take) begin
      state_d = S_DONE;
    end

    // Status outputs are decoded from the next state so they register in step with it.
    in_xfer     = state_d inside {S_HALT, S_ACCESS, S_RWAIT, S_EMIT};
    halt_d      = in_xfer;
    acc_wr_d    = in_xfer && write_d;
    busy_d      = (state_d != S_IDLE);
    req_ready_d = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
    rd_valid_d  = (state_d == S_EMIT);
    wr_ready_d  = (state_d == S_ACCESS) && write_d;
`ifdef JB_HS_SEQ_ABORT_EN
    aborted_d   = abort_take;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      write_q     <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      wr_ready_q  <= 1'b0;
      halt_q      <= 1'b0;
      acc_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef JB_HS_SEQ_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      write_q     <= write_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      wr_ready_q  <= wr_ready_d;
      halt_q      <= halt_d;
      acc_wr_q    <= acc_wr_d;
      busy_q      <= busy_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef JB_HS_SEQ_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  // The strobe must coincide with the write handshake, so it is gated by wr_valid directly.
  assign hs_write_enable = wr_ready_q & wr_valid;
  assign hs_data_in      = hs_write_enable ? wr_data : 8'h00;
  assign hs_address      = addr_q;
  assign hs_access_write = acc_wr_q;
  assign processor_halt  = halt_q;
  assign wr_ready        = wr_ready_q;
  assign rd_valid        = rd_valid_q & ~abort_take;
  assign rd_data         = rd_data_q;
  assign req_ready       = req_ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
`ifdef JB_HS_SEQ_ABORT_EN
  assign aborted         = aborted_q;
`endif

endmodule

// File: tb/tb_jailbreak_hs_sequencer.sv
// Scoreboard bench for jailbreak_hs_sequencer: directed scenarios plus randomized block
// transfers against a byte-array reference model of the high-score RAM.
module tb_jailbreak_hs_sequencer;

  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [11:0] req_addr;
  logic [12:0] req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  rd_data;
  logic [11:0] hs_address;
  logic [7:0]  hs_data_in;
  logic [7:0]  hs_data_out;
  logic        hs_write_enable;
  logic        hs_access_write;
  logic        processor_halt;
  logic        busy;
  logic        done;
  logic        error;
`ifdef JB_HS_SEQ_ABORT_EN
  logic        abort;
  logic        aborted;
`endif

  jailbreak_hs_sequencer dut (
    .clk            (clk),
    .reset          (reset),
`ifdef JB_HS_SEQ_ABORT_EN
    .abort          (abort),
    .aborted        (aborted),
`endif
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_data        (rd_data),
    .hs_address     (hs_address),
    .hs_data_in     (hs_data_in),
    .hs_data_out    (hs_data_out),
    .hs_write_enable(hs_write_enable),
    .hs_access_write(hs_access_write),
    .processor_halt (processor_halt),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Core RAM environment: two-stage read pipeline (READ_LATENCY = 2).
  logic [7:0] init_mem [0:4095];
  logic [7:0] ram      [0:4095];
  logic [7:0] pipe1, pipe2;
  logic       ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_mem[i];
    end else if (hs_write_enable) begin
      ram[hs_address] <= hs_data_in;
    end
    pipe1 <= ram[hs_address];
    pipe2 <= pipe1;
  end
  assign hs_data_out = pipe2;

  // Reference model and scoreboard queues.
  logic [7:0]  ref_mem [0:4095];
  logic [7:0]  pend[$];
  logic [7:0]  wr_q[$];
  logic [19:0] exp_wr[$];
  logic [19:0] exp_rd[$];
  int          exp_ev[$];
  bit          wr_gap  = 1'b0;
  bit          rd_rand = 1'b0;
  bit          rd_hold = 1'b0;
  bit          mon_en  = 1'b0;

  // Write byte source.
  initial begin
    bit hs_wr;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    forever begin
      @(negedge clk);
      hs_wr = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (hs_wr && wr_q.size() > 0) void'(wr_q.pop_front());
      if (wr_q.size() > 0 && (!wr_gap || $urandom_range(0, 3) != 0)) begin
        wr_valid = 1'b1;
        wr_data  = wr_q[0];
      end else begin
        wr_valid = 1'b0;
        wr_data  = 8'h00;
      end
    end
  end

  // Read byte sink.
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rd_ready = rd_hold ? 1'b0 : (rd_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe, a read byte or a pulse.
  always @(negedge clk) begin : monitor
    logic [19:0] e;
    int          ev;
    if (mon_en) begin
      if (hs_write_enable) begin
        check("we_under_halt", 32'(processor_halt), 1);
        check("wr_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", 32'(hs_address), 32'(e[19:8]));
          check("wr_data", 32'(hs_data_in), 32'(e[7:0]));
        end
      end
      if (rd_valid && rd_ready) begin
        check("rd_expected", 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          check("rd_addr", 32'(hs_address), 32'(e[19:8]));
          check("rd_data", 32'(rd_data), 32'(e[7:0]));
        end
      end
      if (done || error) begin
        check("ev_expected", 32'(exp_ev.size() > 0), 1);
        if (exp_ev.size() > 0) begin
          ev = exp_ev.pop_front();
          check(done ? "ev_done" : "ev_error", 32'(done ? EV_DONE : EV_ERR), 32'(ev));
          check("ev_halt_low", 32'(processor_halt), 0);
        end
      end
    end
  end

  task automatic send_req(input logic w, input logic [11:0] a, input logic [12:0] l);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = l;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Model: decide the outcome from addr/len arithmetic, queue expected bytes, then issue.
  task automatic issue(input logic w, input logic [11:0] a, input logic [12:0] l);
    int          endv;
    logic [11:0] ai;
    endv = int'(a) + int'(l);
    if (l == 0) begin
      exp_ev.push_back(EV_DONE);
    end else if (endv > 4096) begin
      exp_ev.push_back(EV_ERR);
    end else begin
      for (int i = 0; i < int'(l); i++) begin
        ai = 12'(int'(a) + i);
        if (w) begin
          wr_q.push_back(pend[i]);
          exp_wr.push_back({ai, pend[i]});
          ref_mem[ai] = pend[i];
        end else begin
          exp_rd.push_back({ai, ref_mem[ai]});
        end
      end
      exp_ev.push_back(EV_DONE);
    end
    pend.delete();
    send_req(w, a, l);
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while (!(exp_ev.size() == 0 && req_ready === 1'b1) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < max_cyc), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_halt, t_w0, t_wl, t_done, nwe, cnt, n;
    int w, len, a;
    logic [7:0] b;

    reset     = 1'b1;
    ram_load  = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_len   = '0;
`ifdef JB_HS_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) begin
      init_mem[i] = 8'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    init_mem[12'hFFE] = 8'h5A; ref_mem[12'hFFE] = 8'h5A;
    init_mem[12'hFFF] = 8'h6B; ref_mem[12'hFFF] = 8'h6B;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_halt", 32'(processor_halt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done_err", 32'({done, error, rd_valid, wr_ready, hs_write_enable, hs_access_write}), 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    ram_load = 1'b0;
    mon_en   = 1'b1;

    // Back-to-back write: halt, settle, three consecutive strobes, done.
    pend.push_back(8'hA1); pend.push_back(8'hB2); pend.push_back(8'hC3);
    issue(1'b1, 12'h010, 13'd3);
    t_halt = -1; t_w0 = -1; t_wl = -1; t_done = -1; nwe = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (processor_halt && t_halt < 0) t_halt = i;
      if (hs_write_enable) begin
        if (t_w0 < 0) t_w0 = i;
        t_wl = i;
        nwe++;
        check("t1_access_write", 32'(hs_access_write), 1);
      end
      if (done && t_done < 0) begin
        t_done = i;
        check("t1_acc_wr_at_done", 32'(hs_access_write), 0);
      end
    end
    check("t1_settle", 32'(t_w0 - t_halt), 4);
    check("t1_strobes", 32'(nwe), 3);
    check("t1_consecutive", 32'(t_wl - t_w0), 2);
    check("t1_done_lag", 32'(t_done - t_wl), 1);
    wait_idle("t1_idle", 100);

    // Read at the top of the address space.
    issue(1'b0, 12'hFFE, 13'd2);
    wait_idle("t2_idle", 100);

    // Read with the consumer stalled on byte 0.
    rd_hold = 1'b1;
    issue(1'b0, 12'h000, 13'd2);
    n = 0;
    while (rd_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t3_rd_valid_wait", 32'(n < 40), 1);
    repeat (10) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(rd_valid), 1);
      check("t3_hold_data", 32'(rd_data), 32'(ref_mem[0]));
      check("t3_hold_addr", 32'(hs_address), 0);
    end
    rd_hold = 1'b0;
    wait_idle("t3_idle", 100);

    // Out-of-range request.
    issue(1'b0, 12'hFFF, 13'd2);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (error) cnt++;
      check("t4_no_halt", 32'(processor_halt), 0);
      check("t4_req_ready", 32'(req_ready), 1);
    end
    check("t4_error_pulses", 32'(cnt), 1);
    wait_idle("t4_idle", 20);

    // Zero-length request.
    issue(1'b1, 12'h123, 13'd0);
    cnt = 0; t_done = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (t_done < 0) t_done = i;
      end
      check("t5_no_halt", 32'(processor_halt), 0);
      check("t5_no_strobe", 32'(hs_write_enable), 0);
    end
    check("t5_done_once", 32'(cnt), 1);
    check("t5_done_soon", 32'(t_done >= 0 && t_done <= 1), 1);
    wait_idle("t5_idle", 20);

    // Randomized transfers with stalls on both streams.
    wr_gap  = 1'b1;
    rd_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      w   = $urandom_range(0, 1);
      len = $urandom_range(0, 8);
      if ($urandom_range(0, 5) == 0) a = 4095 - $urandom_range(0, 7);
      else a = $urandom_range(0, 4095);
      for (int i = 0; i < len; i++) pend.push_back(8'($urandom));
      issue(1'(w), 12'(a), 13'(len));
      wait_idle("rnd_idle", 600);
      check("rnd_wr_drained", 32'(exp_wr.size()), 0);
      check("rnd_rd_drained", 32'(exp_rd.size()), 0);
    end
    wr_gap  = 1'b0;
    rd_rand = 1'b0;

    // Reset in the middle of a 4-byte write after one byte.
    b = 8'h5C;
    wr_q.push_back(b);
    exp_wr.push_back({12'h100, b});
    ref_mem[12'h100] = b;
    send_req(1'b1, 12'h100, 13'd4);
    n = 0;
    while (exp_wr.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("t6_first_byte", 32'(n < 40), 1);
    repeat (2) @(negedge clk);
    check("t6_halt_before", 32'(processor_halt), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_halt_after", 32'(processor_halt), 0);
    check("t6_req_ready", 32'(req_ready), 1);
    check("t6_busy", 32'(busy), 0);
    nwe = 0;
    repeat (10) begin
      @(negedge clk);
      if (hs_write_enable) nwe++;
    end
    check("t6_no_strobes", 32'(nwe), 0);

`ifdef JB_HS_SEQ_ABORT_EN
    // Abort in the middle of a 4-byte write after one byte.
    b = 8'h77;
    wr_q.push_back(b);
    exp_wr.push_back({12'h200, b});
    ref_mem[12'h200] = b;
    exp_ev.push_back(EV_DONE);
    send_req(1'b1, 12'h200, 13'd4);
    n = 0;
    while (exp_wr.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ab_first_byte", 32'(n < 40), 1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        check("ab_aborted_with_done", 32'(aborted), 1);
      end
      check("ab_no_strobe", 32'(hs_write_enable), 0);
    end
    check("ab_done_once", 32'(cnt), 1);
    wait_idle("ab_idle", 20);
`endif

    // Read back the byte that landed before the reset.
    issue(1'b0, 12'h100, 13'd1);
    wait_idle("t7_idle", 100);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
